// File: rtl/hamming_pkg.sv
// hamming_pkg: shared types and constants for the Hamming(7,4) serial receiver
package hamming_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, DECODE} rx_state_t;
   typedef logic [7:1] codeword_t;
   typedef logic [2:0] syndrome_t;
   localparam int CW_BITS = 7;
   localparam int DATA_BITS = 4;
endpackage

// File: rtl/hamming74_decode.sv
// hamming74_decode: combinational Hamming(7,4) syndrome, single-bit correction and data extraction
// Ports: cw (codeword, position 1..7), data ({d4,d3,d2,d1} after correction),
//        syn ({s4,s2,s1}, equals the failing position), err (syndrome nonzero)
module hamming74_decode
   import hamming_pkg::*;
(
   input  codeword_t              cw,
   output logic [DATA_BITS-1:0]   data,
   output syndrome_t              syn,
   output logic                   err
);
   codeword_t fixed;
   always_comb begin
      syn = {cw[4] ^ cw[5] ^ cw[6] ^ cw[7],
             cw[2] ^ cw[3] ^ cw[6] ^ cw[7],
             cw[1] ^ cw[3] ^ cw[5] ^ cw[7]};
      fixed = cw;
      for (int i = 1; i <= CW_BITS; i++) fixed[i] = cw[i] ^ (syn == 3'(i));
   end
   assign err  = |syn;
   assign data = {fixed[7], fixed[6], fixed[5], fixed[3]};
endmodule

// File: rtl/hamming_rx.sv
// hamming_rx: UART-style receiver for one Hamming(7,4) codeword per frame, with correction
// Ports: clk, rst_n (sync, active-low), rx_in (async line, idle high),
//        data_out/syndrome/err_corrected (last accepted codeword), data_valid (pulse),
//        frame_err (pulse on bad stop bit), busy (FSM not idle)
module hamming_rx
   import hamming_pkg::*;
#(
   parameter int CLKS_PER_BIT = 2700
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_in,
   output logic [3:0] data_out,
   output logic [2:0] syndrome,
   output logic       err_corrected,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   rx_state_t         state, state_next;
   logic              rx_meta, rx_s, tick;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        bitcnt;
   codeword_t         sr;
   logic [3:0]        dec_data;
   syndrome_t         dec_syn;
   logic              dec_err;

   hamming74_decode u_dec (.cw(sr), .data(dec_data), .syn(dec_syn), .err(dec_err));

   always_ff @(posedge clk) begin
      if (!rst_n) {rx_s, rx_meta} <= 2'b11;
      else {rx_s, rx_meta} <= {rx_meta, rx_in};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_next;
   end

   // START samples half a bit in, so every later sample lands mid-bit
   always_comb tick = cnt == CNT_W'((state == START ? CLKS_PER_BIT / 2 : CLKS_PER_BIT) - 1);

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    state_next = rx_s ? IDLE : START;
         START:   state_next = tick ? (rx_s ? IDLE : DATA) : START;
         DATA:    state_next = (tick && bitcnt == 3'(CW_BITS - 1)) ? STOP : DATA;
         STOP:    state_next = tick ? (rx_s ? DECODE : IDLE) : STOP;
         DECODE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb busy = state != IDLE;

   // Outputs load on the stop-sample edge so they are stable while data_valid is high
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt           <= '0;
         bitcnt        <= '0;
         sr            <= '0;
         data_out      <= '0;
         syndrome      <= '0;
         err_corrected <= 1'b0;
         data_valid    <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         cnt        <= (state == IDLE || tick || state_next != state) ? '0 : cnt + CNT_W'(1);
         bitcnt     <= state != DATA ? 3'd0 : bitcnt + 3'(tick);
         sr         <= (state == DATA && tick) ? {rx_s, sr[7:2]} : sr;
         data_valid <= state == STOP && tick && rx_s;
         frame_err  <= state == STOP && tick && !rx_s;
         if (state == STOP && tick && rx_s) begin
            data_out      <= dec_data;
            syndrome      <= dec_syn;
            err_corrected <= dec_err;
         end
      end
   end
endmodule
